// File: rtl/soc_fpga_ram_dp_be.sv
// soc_fpga_ram_dp_be
//
// Single-clock dual-port RAM with byte-write enables and a built-in clear sequencer.
//   Port A : read/write, chip enable, per-lane byte enables, selectable read-during-write.
//   Port B : read-only.
//   Clear  : fills every word with INITVAL after reset (INITONRESET) or on InitStart.
//            While it runs (InitBusy = 1) user accesses on both ports are ignored.
//
// Ports
//   PortAClk         clock for both ports and the clear sequencer
//   PortARstN        asynchronous active-low reset (output/pipeline/FSM state only)
//   PortAChipEnable  port A access qualifier
//   PortAWriteEnable port A write (read when low), qualified by PortAChipEnable
//   PortAByteEnable  per-lane write mask, bit i covers [i*BYTEWIDTH +: BYTEWIDTH]
//   PortAAddr        port A word address
//   PortADataIn      port A write data
//   PortADataOut     port A read data, latency 1 + OUTREG
//   PortADataValid   one-cycle pulse per accepted port A read
//   PortBChipEnable  port B read request
//   PortBAddr        port B word address
//   PortBDataOut     port B read data, latency 1 + OUTREG
//   PortBDataValid   one-cycle pulse per accepted port B read
//   InitStart        request a clear sequence (ignored while one is running)
//   InitBusy         clear sequence in progress
//
// RDMODE (port A output on a write cycle):
//   0 read-first  : old word, valid
//   1 write-first : old word with enabled lanes replaced by write data, valid
//   2 no-change   : output holds, no valid
// Port B always sees the old word on a same-address collision with a port A write.

module soc_fpga_ram_dp_be #(
  parameter int unsigned          DATAWIDTH   = 32,
  parameter int unsigned          ADDRWIDTH   = 10,
  parameter int unsigned          BYTEWIDTH   = 8,
  parameter int unsigned          RDMODE      = 0,
  parameter int unsigned          OUTREG      = 0,
  parameter logic [DATAWIDTH-1:0] INITVAL     = '0,
  parameter bit                   INITONRESET = 1'b1
) (
  input  logic                             PortAClk,
  input  logic                             PortARstN,
  input  logic                             PortAChipEnable,
  input  logic                             PortAWriteEnable,
  input  logic [DATAWIDTH/BYTEWIDTH-1:0]   PortAByteEnable,
  input  logic [ADDRWIDTH-1:0]             PortAAddr,
  input  logic [DATAWIDTH-1:0]             PortADataIn,
  output logic [DATAWIDTH-1:0]             PortADataOut,
  output logic                             PortADataValid,
  input  logic                             PortBChipEnable,
  input  logic [ADDRWIDTH-1:0]             PortBAddr,
  output logic [DATAWIDTH-1:0]             PortBDataOut,
  output logic                             PortBDataValid,
  input  logic                             InitStart,
  output logic                             InitBusy
);

  localparam int unsigned NBYTES   = DATAWIDTH / BYTEWIDTH;
  localparam int unsigned MEMDEPTH = 2 ** ADDRWIDTH;
  localparam logic [ADDRWIDTH-1:0] LastAddr = '1;

  if (DATAWIDTH % BYTEWIDTH != 0) begin : genWidthCheck
    $error("soc_fpga_ram_dp_be: DATAWIDTH must be a multiple of BYTEWIDTH");
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {StIdle, StInit} state_e;

  localparam state_e ResetState = INITONRESET ? StInit : StIdle;

  state_e                 stateQ, stateD;
  logic [ADDRWIDTH-1:0]   initCntQ, initCntD;

  always_comb begin
    stateD   = stateQ;
    initCntD = initCntQ;
    unique case (stateQ)
      StIdle: begin
        if (InitStart) begin
          stateD   = StInit;
          initCntD = '0;
        end
      end
      StInit: begin
        // InitStart is deliberately not looked at here: no restart while busy.
        if (initCntQ == LastAddr) begin
          stateD   = StIdle;
          initCntD = '0;
        end else begin
          initCntD = initCntQ + ADDRWIDTH'(1);
        end
      end
      default: begin
        stateD   = StIdle;
        initCntD = '0;
      end
    endcase
  end

  always_ff @(posedge PortAClk or negedge PortARstN) begin
    if (!PortARstN) begin
      stateQ   <= ResetState;
      initCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      initCntQ <= initCntD;
    end
  end

  assign InitBusy = (stateQ == StInit);

  // ---------------------------------------------------------------------------
  // Access qualification
  // ---------------------------------------------------------------------------
  logic aWrite, aRead, bRead;

  assign aWrite = PortAChipEnable & ~InitBusy &  PortAWriteEnable;
  assign aRead  = PortAChipEnable & ~InitBusy & ~PortAWriteEnable;
  assign bRead  = PortBChipEnable & ~InitBusy;

  // ---------------------------------------------------------------------------
  // Storage (not reset)
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] mem [MEMDEPTH];

  always_ff @(posedge PortAClk) begin
    if (InitBusy) begin
      mem[initCntQ] <= INITVAL;
    end else if (aWrite) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (PortAByteEnable[i]) begin
          mem[PortAAddr][i*BYTEWIDTH +: BYTEWIDTH] <= PortADataIn[i*BYTEWIDTH +: BYTEWIDTH];
        end
      end
    end
  end

  // Pre-edge contents; both ports therefore see the old word on a collision.
  logic [DATAWIDTH-1:0] aOld, bOld, aMerged;

  assign aOld = mem[PortAAddr];
  assign bOld = mem[PortBAddr];

  always_comb begin
    aMerged = aOld;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (PortAByteEnable[i]) begin
        aMerged[i*BYTEWIDTH +: BYTEWIDTH] = PortADataIn[i*BYTEWIDTH +: BYTEWIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First output stage
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] aData1Q, aData1D, bData1Q, bData1D;
  logic                 aValid1Q, aValid1D, bValid1Q, bValid1D;

  always_comb begin
    aData1D  = aData1Q;
    aValid1D = 1'b0;
    if (aRead) begin
      aData1D  = aOld;
      aValid1D = 1'b1;
    end else if (aWrite) begin
      if (RDMODE == 0) begin
        aData1D  = aOld;
        aValid1D = 1'b1;
      end else if (RDMODE == 1) begin
        aData1D  = aMerged;
        aValid1D = 1'b1;
      end
      // Other modes: no-change, output and valid stay as defaulted.
    end
  end

  always_comb begin
    bData1D  = bData1Q;
    bValid1D = 1'b0;
    if (bRead) begin
      bData1D  = bOld;
      bValid1D = 1'b1;
    end
  end

  always_ff @(posedge PortAClk or negedge PortARstN) begin
    if (!PortARstN) begin
      aData1Q  <= '0;
      aValid1Q <= 1'b0;
      bData1Q  <= '0;
      bValid1Q <= 1'b0;
    end else begin
      aData1Q  <= aData1D;
      aValid1Q <= aValid1D;
      bData1Q  <= bData1D;
      bValid1Q <= bValid1D;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output register
  // ---------------------------------------------------------------------------
  if (OUTREG != 0) begin : genOutReg
    logic [DATAWIDTH-1:0] aData2Q, bData2Q;
    logic                 aValid2Q, bValid2Q;

    // Data only advances with a valid so the output holds between reads.
    always_ff @(posedge PortAClk or negedge PortARstN) begin
      if (!PortARstN) begin
        aData2Q  <= '0;
        aValid2Q <= 1'b0;
        bData2Q  <= '0;
        bValid2Q <= 1'b0;
      end else begin
        aValid2Q <= aValid1Q;
        bValid2Q <= bValid1Q;
        if (aValid1Q) begin
          aData2Q <= aData1Q;
        end
        if (bValid1Q) begin
          bData2Q <= bData1Q;
        end
      end
    end

    assign PortADataOut   = aData2Q;
    assign PortADataValid = aValid2Q;
    assign PortBDataOut   = bData2Q;
    assign PortBDataValid = bValid2Q;
  end else begin : genNoOutReg
    assign PortADataOut   = aData1Q;
    assign PortADataValid = aValid1Q;
    assign PortBDataOut   = bData1Q;
    assign PortBDataValid = bValid1Q;
  end

endmodule

// File: tb/tb_soc_fpga_ram_dp_be.sv
// Bench for soc_fpga_ram_dp_be. Three instances share one stimulus:
//   dut 0 : defaults (read-first, no output register, INITVAL 0)
//   dut 1 : write-first, output register, INITVAL 0xDEADBEEF
//   dut 2 : no-change, no output register, INITVAL 0
module tb_soc_fpga_ram_dp_be;

  logic        clk = 1'b0;
  logic        rstN;
  logic        aCe, aWe, bCe, initStart;
  logic [3:0]  aBe;
  logic [9:0]  aAddr, bAddr;
  logic [31:0] aDin;

  logic [31:0] aData [3];
  logic [31:0] bData [3];
  logic        aValid [3];
  logic        bValid [3];
  logic        busy [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  soc_fpga_ram_dp_be dut0 (
    .PortAClk(clk), .PortARstN(rstN), .PortAChipEnable(aCe), .PortAWriteEnable(aWe),
    .PortAByteEnable(aBe), .PortAAddr(aAddr), .PortADataIn(aDin),
    .PortADataOut(aData[0]), .PortADataValid(aValid[0]),
    .PortBChipEnable(bCe), .PortBAddr(bAddr),
    .PortBDataOut(bData[0]), .PortBDataValid(bValid[0]),
    .InitStart(initStart), .InitBusy(busy[0])
  );

  soc_fpga_ram_dp_be #(.RDMODE(1), .OUTREG(1), .INITVAL(32'hDEADBEEF)) dut1 (
    .PortAClk(clk), .PortARstN(rstN), .PortAChipEnable(aCe), .PortAWriteEnable(aWe),
    .PortAByteEnable(aBe), .PortAAddr(aAddr), .PortADataIn(aDin),
    .PortADataOut(aData[1]), .PortADataValid(aValid[1]),
    .PortBChipEnable(bCe), .PortBAddr(bAddr),
    .PortBDataOut(bData[1]), .PortBDataValid(bValid[1]),
    .InitStart(initStart), .InitBusy(busy[1])
  );

  soc_fpga_ram_dp_be #(.RDMODE(2)) dut2 (
    .PortAClk(clk), .PortARstN(rstN), .PortAChipEnable(aCe), .PortAWriteEnable(aWe),
    .PortAByteEnable(aBe), .PortAAddr(aAddr), .PortADataIn(aDin),
    .PortADataOut(aData[2]), .PortADataValid(aValid[2]),
    .PortBChipEnable(bCe), .PortBAddr(bAddr),
    .PortBDataOut(bData[2]), .PortBDataValid(bValid[2]),
    .InitStart(initStart), .InitBusy(busy[2])
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One port A access; returns at the sample after the request edge.
  task automatic aOp(input logic we, input logic [3:0] be, input logic [9:0] addr,
                     input logic [31:0] data);
    aCe = 1'b1; aWe = we; aBe = be; aAddr = addr; aDin = data;
    tick();
    aCe = 1'b0; aWe = 1'b0; aBe = 4'h0;
  endtask

  task automatic bReq(input logic [9:0] addr);
    bCe = 1'b1; bAddr = addr;
    tick();
    bCe = 1'b0;
  endtask

  // Checks latency-1 outputs (dut0, dut2) now and latency-2 (dut1) one cycle later.
  task automatic aCheck(input string tag, input logic [31:0] d0, input logic v0,
                        input logic [31:0] d1, input logic [31:0] d2, input logic v2);
    checkEq({tag, "_a0_data"}, aData[0], d0);
    checkEq({tag, "_a0_valid"}, {31'd0, aValid[0]}, {31'd0, v0});
    checkEq({tag, "_a2_data"}, aData[2], d2);
    checkEq({tag, "_a2_valid"}, {31'd0, aValid[2]}, {31'd0, v2});
    checkEq({tag, "_a1_valid_early"}, {31'd0, aValid[1]}, 32'd0);
    tick();
    checkEq({tag, "_a1_data"}, aData[1], d1);
    checkEq({tag, "_a1_valid"}, {31'd0, aValid[1]}, 32'd1);
    checkEq({tag, "_a0_pulse"}, {31'd0, aValid[0]}, 32'd0);
  endtask

  task automatic bCheck(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2);
    checkEq({tag, "_b0_data"}, bData[0], d0);
    checkEq({tag, "_b0_valid"}, {31'd0, bValid[0]}, 32'd1);
    checkEq({tag, "_b2_data"}, bData[2], d2);
    checkEq({tag, "_b1_valid_early"}, {31'd0, bValid[1]}, 32'd0);
    tick();
    checkEq({tag, "_b1_data"}, bData[1], d1);
    checkEq({tag, "_b1_valid"}, {31'd0, bValid[1]}, 32'd1);
    checkEq({tag, "_b0_pulse"}, {31'd0, bValid[0]}, 32'd0);
  endtask

  // Counts edges after reset release until InitBusy drops.
  task automatic countBusyAfterRelease(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy[0] && n < 2000);
    checkEq(tag, n, 32'd1024);
  endtask

  initial begin
    int n;
    rstN = 1'b1; aCe = 1'b0; aWe = 1'b0; aBe = 4'h0; aAddr = '0; aDin = '0;
    bCe = 1'b0; bAddr = '0; initStart = 1'b0;
    #2 rstN = 1'b0;
    tick();

    // Reset state
    checkEq("rst_busy0", {31'd0, busy[0]}, 32'd1);
    checkEq("rst_busy1", {31'd0, busy[1]}, 32'd1);
    checkEq("rst_a0_data", aData[0], 32'h0);
    checkEq("rst_a0_valid", {31'd0, aValid[0]}, 32'd0);
    checkEq("rst_b1_data", bData[1], 32'h0);
    checkEq("rst_b1_valid", {31'd0, bValid[1]}, 32'd0);
    repeat (3) tick();
    rstN = 1'b1;
    countBusyAfterRelease("init_len_reset");

    // Cleared contents through port B
    bReq(10'd0);    bCheck("clr0",    32'h0, 32'hDEADBEEF, 32'h0);
    bReq(10'd511);  bCheck("clr511",  32'h0, 32'hDEADBEEF, 32'h0);
    bReq(10'd1023); bCheck("clr1023", 32'h0, 32'hDEADBEEF, 32'h0);

    // Byte-enable merge at 0x010
    aOp(1'b1, 4'b1111, 10'h010, 32'hAABBCCDD);
    aCheck("wr_full", 32'h0, 1'b1, 32'hAABBCCDD, 32'h0, 1'b0);
    aOp(1'b1, 4'b0101, 10'h010, 32'h11223344);
    aCheck("wr_be", 32'hAABBCCDD, 1'b1, 32'hAA22CC44, 32'h0, 1'b0);
    aOp(1'b0, 4'b0000, 10'h010, 32'h0);
    aCheck("rd_be", 32'hAA22CC44, 1'b1, 32'hAA22CC44, 32'hAA22CC44, 1'b1);

    // Read-during-write modes at 0x020
    aOp(1'b1, 4'b1111, 10'h020, 32'hAABBCCDD);
    aCheck("wr20", 32'h0, 1'b1, 32'hAABBCCDD, 32'hAA22CC44, 1'b0);
    aOp(1'b0, 4'b0000, 10'h010, 32'h0);
    aCheck("rd10", 32'hAA22CC44, 1'b1, 32'hAA22CC44, 32'hAA22CC44, 1'b1);
    aOp(1'b1, 4'b0011, 10'h020, 32'h55667788);
    aCheck("rdw", 32'hAABBCCDD, 1'b1, 32'hAABB7788, 32'hAA22CC44, 1'b0);
    aOp(1'b0, 4'b0000, 10'h020, 32'h0);
    aCheck("rd20", 32'hAABB7788, 1'b1, 32'hAABB7788, 32'hAABB7788, 1'b1);

    // A write / B read collision at 0x3FF
    aCe = 1'b1; aWe = 1'b1; aBe = 4'hF; aAddr = 10'h3FF; aDin = 32'h12345678;
    bCe = 1'b1; bAddr = 10'h3FF;
    tick();
    aCe = 1'b0; aWe = 1'b0; bCe = 1'b0;
    bCheck("coll", 32'h0, 32'hDEADBEEF, 32'h0);
    bReq(10'h3FF);
    bCheck("coll_after", 32'h12345678, 32'h12345678, 32'h12345678);

    // Clear on request with traffic; the read in the start cycle is still accepted
    initStart = 1'b1; bCe = 1'b1; bAddr = 10'h010;
    tick();
    initStart = 1'b0; bAddr = 10'h3FF;
    aCe = 1'b1; aWe = 1'b1; aBe = 4'hF; aAddr = 10'h005; aDin = 32'h0BADF00D;
    checkEq("start_busy", {31'd0, busy[0]}, 32'd1);
    checkEq("start_b0_data", bData[0], 32'hAA22CC44);
    checkEq("start_b0_valid", {31'd0, bValid[0]}, 32'd1);
    n = 0;
    while (busy[0] && n < 2000) begin
      n++;
      initStart = (n == 100);
      if (n == 10) begin
        checkEq("busy_b0_hold", bData[0], 32'hAA22CC44);
        checkEq("busy_b0_valid", {31'd0, bValid[0]}, 32'd0);
        checkEq("busy_b1_hold", bData[1], 32'hAA22CC44);
        checkEq("busy_b1_valid", {31'd0, bValid[1]}, 32'd0);
        checkEq("busy_a0_valid", {31'd0, aValid[0]}, 32'd0);
        checkEq("busy_a1_hold", aData[1], 32'h12345678);
        checkEq("busy_a2_hold", aData[2], 32'hAABB7788);
      end
      tick();
    end
    initStart = 1'b0; aCe = 1'b0; aWe = 1'b0; bCe = 1'b0;
    checkEq("init_len_req", n, 32'd1024);

    // Full readback, pipelined on port B
    for (int i = 0; i <= 1024; i++) begin
      bCe = (i < 1024);
      bAddr = 10'(i);
      tick();
      if (i < 1024) begin
        checkEq("rb_b0", bData[0], 32'h0);
        checkEq("rb_b2", bData[2], 32'h0);
      end
      if (i > 0) begin
        checkEq("rb_b1", bData[1], 32'hDEADBEEF);
      end
    end
    bCe = 1'b0;

    // Reset abort partway through a clear
    aOp(1'b1, 4'hF, 10'h001, 32'hCAFEF00D);
    tick();
    aOp(1'b0, 4'h0, 10'h001, 32'h0);
    checkEq("pre_a0", aData[0], 32'hCAFEF00D);
    tick();
    bReq(10'h001);
    bCheck("pre_b", 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);
    initStart = 1'b1;
    tick();
    initStart = 1'b0;
    repeat (300) tick();
    rstN = 1'b0;
    #1;
    checkEq("abort_a0", aData[0], 32'h0);
    checkEq("abort_b0", bData[0], 32'h0);
    checkEq("abort_a1", aData[1], 32'h0);
    checkEq("abort_b1", bData[1], 32'h0);
    checkEq("abort_busy", {31'd0, busy[0]}, 32'd1);
    repeat (3) tick();
    rstN = 1'b1;
    countBusyAfterRelease("init_len_abort");
    bReq(10'h001);
    bCheck("post_abort", 32'h0, 32'hDEADBEEF, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
